// File: rtl/sub_arbiter_pkg.sv
// Shared definitions for the subtract arbiter: FSM encoding and default datapath sizes.
// The default width is shared with the other synth datapaths.
package sub_arbiter_pkg;

    localparam int DEFAULT_WIDTH   = 12;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_arbiter_subtract_unit.sv
// Combinational unsigned subtractor shared by all requesters.
// overflow is the borrow out of the MSB; the result wraps modulo 2^WIDTH.
module subtract_unit
    import sub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH:0] diff;

    assign diff     = {1'b0, lhs} - {1'b0, rhs};
    assign result   = diff[WIDTH-1:0];
    assign overflow = diff[WIDTH];

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtract datapath among NUM_REQ requesters.
// IDLE -> EXEC -> DONE; DONE can reissue directly to EXEC for 2-cycle throughput.
module sub_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*WIDTH-1:0] req_rhs,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         result,
    output logic                     overflow,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               overflow_reg, overflow_next;
    logic [WIDTH-1:0]   lhs_reg, lhs_next;
    logic [WIDTH-1:0]   rhs_reg, rhs_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               pick_valid;
    logic [WIDTH-1:0]   lhs_arr [NUM_REQ];
    logic [WIDTH-1:0]   rhs_arr [NUM_REQ];
    logic [WIDTH-1:0]   sub_result;
    logic               sub_overflow;

    // Position k in the priority order starting at base; wraps explicitly so
    // non-power-of-two NUM_REQ never produces an out-of-range index.
    function automatic logic [IDX_W-1:0] rr_offset(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign lhs_arr[gi]     = req_lhs[gi*WIDTH +: WIDTH];
            assign rhs_arr[gi]     = req_rhs[gi*WIDTH +: WIDTH];
            assign pick_onehot[gi] = pick_valid && (pick_idx == IDX_W'(gi));
        end
    endgenerate

    // The just-acknowledged requester still holds req during DONE; mask it out.
    assign arb_req = (state_reg == ST_DONE) ? (req & ~grant_reg) : req;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_offset(rr_ptr_reg, k);
            if (arb_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    subtract_unit #(
        .WIDTH(WIDTH)
    ) u_sub (
        .lhs      (lhs_reg),
        .rhs      (rhs_reg),
        .result   (sub_result),
        .overflow (sub_overflow)
    );

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ack_next      = '0;
        result_next   = result_reg;
        overflow_next = overflow_reg;
        lhs_next      = lhs_reg;
        rhs_next      = rhs_reg;
        rr_ptr_next   = rr_ptr_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (pick_valid) begin
                    lhs_next    = lhs_arr[pick_idx];
                    rhs_next    = rhs_arr[pick_idx];
                    grant_next  = pick_onehot;
                    rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_next  = ST_EXEC;
                end else begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_next   = sub_result;
                overflow_next = sub_overflow;
                ack_next      = grant_reg;
                state_next    = ST_DONE;
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            ack_reg      <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            lhs_reg      <= '0;
            rhs_reg      <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ack_reg      <= ack_next;
            result_reg   <= result_next;
            overflow_reg <= overflow_next;
            lhs_reg      <= lhs_next;
            rhs_reg      <= rhs_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    assign grant    = grant_reg;
    assign ack      = ack_reg;
    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboard bench for sub_arbiter: expected acks are planned with a reference
// round-robin model when stimulus is queued, then popped as acks appear.
module tb_sub_arbiter;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_lhs;
    logic [N*W-1:0] req_rhs;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           overflow;
    logic           busy;

    sub_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_lhs  (req_lhs),
        .req_rhs  (req_rhs),
        .grant    (grant),
        .ack      (ack),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] op_a [N][16];
    logic [W-1:0] op_b [N][16];
    int           op_wr [N];
    int           op_rd [N];
    int           model_rr = 0;
    bit           gap_check = 1'b0;
    int           last_ack = -1;
    int           lat_start = -1;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.idx = i;
        e.res = a - b;
        e.ovf = (a < b);
        return e;
    endfunction

    task automatic add_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i][op_wr[i]] = a;
        op_b[i][op_wr[i]] = b;
        op_wr[i]++;
    endtask

    task automatic load(input int i);
        req_lhs[i*W +: W] = op_a[i][op_rd[i]];
        req_rhs[i*W +: W] = op_b[i][op_rd[i]];
        req[i]            = 1'b1;
        op_rd[i]++;
    endtask

    // Reference arbitration over all queued operations, in service order.
    task automatic plan();
        int  cnt [N];
        int  rd [N];
        int  c;
        bit  found;
        for (int i = 0; i < N; i++) begin
            cnt[i] = op_wr[i] - op_rd[i];
            rd[i]  = op_rd[i];
        end
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            c = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && cnt[(model_rr + k) % N] > 0) begin
                    c     = (model_rr + k) % N;
                    found = 1'b1;
                end
            end
            if (found) begin
                sb.push_back(mk(c, op_a[c][rd[c]], op_b[c][rd[c]]));
                rd[c]++;
                cnt[c]--;
                model_rr = (c + 1) % N;
            end
        end
    endtask

    task automatic start();
        plan();
        for (int i = 0; i < N; i++) begin
            if (op_rd[i] < op_wr[i]) load(i);
        end
    endtask

    task automatic run(input int max_cycles);
        int   n;
        int   idx;
        exp_t e;
        n        = 0;
        last_ack = -1;
        while (sb.size() > 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
            if (ack != '0) begin
                chk("ack_onehot", $countones(ack), 1);
                idx = 0;
                for (int i = N - 1; i >= 0; i--) if (ack[i]) idx = i;
                e = sb.pop_front();
                $display("ack req=%0d result=%0d overflow=%0d cycle=%0d", idx, result, overflow, cyc);
                chk("ack_idx", idx, e.idx);
                chk("result", result, e.res);
                chk("overflow", overflow, e.ovf);
                if (gap_check && last_ack >= 0) chk("ack_gap", cyc - last_ack, 2);
                if (lat_start >= 0) begin
                    chk("latency", cyc - lat_start, 2);
                    lat_start = -1;
                end
                last_ack = cyc;
                req[idx] = 1'b0;
                if (op_rd[idx] < op_wr[idx]) load(idx);
            end
        end
        if (sb.size() > 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic settle();
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack", ack, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        req     = '0;
        req_lhs = '0;
        req_rhs = '0;
        for (int i = 0; i < N; i++) begin
            op_wr[i] = 0;
            op_rd[i] = 0;
        end

        // Reset state, then stay idle after release with no requests.
        #1;
        chk("reset_outs", {grant, ack, result, overflow, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_busy", busy, 0);
        end

        // Single operation with latency check.
        add_op(0, 20, 5);
        plan();
        load(0);
        lat_start = cyc;
        @(negedge clk);
        chk("grant_single", grant, 4'b0001);
        chk("busy_single", busy, 1);
        run(20);
        settle();
        chk("result_hold", result, 15);

        // Borrow cases.
        add_op(1, 10, 30);
        start();
        run(20);
        settle();
        add_op(3, 0, 1);
        start();
        run(20);
        settle();

        // Contention, two rounds; back-to-back acks two cycles apart.
        gap_check = 1'b1;
        add_op(0, 100, 1);
        add_op(2, 50, 50);
        start();
        run(20);
        settle();
        add_op(0, 100, 1);
        add_op(2, 50, 50);
        start();
        run(20);
        settle();
        gap_check = 1'b0;

        // Abort: reset while in EXEC; the request is re-served after release.
        add_op(3, 700, 701);
        load(3);
        @(negedge clk);
        chk("abort_grant", grant, 4'b1000);
        chk("abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_async_outs", {grant, ack, result, overflow, busy}, 0);
        @(negedge clk);
        chk("abort_no_ack", ack, 0);
        @(negedge clk);
        chk("abort_no_ack2", ack, 0);
        rst_n    = 1'b1;
        model_rr = 0;
        plan();
        sb.push_back(mk(3, 700, 701));
        model_rr = 0;
        run(20);
        settle();

        // Fairness under continuous load: 4 ops per requester.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) begin
                add_op(i, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)));
            end
        end
        gap_check = 1'b1;
        start();
        run(200);
        gap_check = 1'b0;
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
